serial_bit_feeder: RTL
======================

// Module: serial_bit_feeder
// PURPOSE
//   Upstream stage of the conditional-invert mux: serializes a parallel word into the
//   mux data input (x) and drives its select input for the whole word. One word is
//   accepted per frame through a valid/ready handshake. Bits go out one per enabled
//   cycle, with frame start/done strobes for the downstream consumer.
// PARAMETERS
//   WIDTH      8   bits per word/frame (>=2)
//   LSB_FIRST  0   0: MSB shifted out first; 1: LSB shifted out first
// PORTS
//   clk          in   1      single clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   load_valid   in   1      upstream offers load_data/load_invert
//   load_ready   out  1      block accepts a word this cycle
//   load_data    in   WIDTH  word to serialize
//   load_invert  in   1      invert request for this word
//   advance      in   1      downstream enable; 0 = hold current bit (stall)
//   bit_out      out  1      serial data to mux x
//   inv_sel      out  1      to mux select; constant for the whole frame
//   bit_valid    out  1      bit_out/inv_sel carry a live bit
//   frame_start  out  1      high while the first bit of a frame is presented
//   frame_done   out  1      high while the last bit of a frame is presented
//   bit_index    out  $clog2(WIDTH)  position of the presented bit, 0..WIDTH-1
// BEHAVIOUR
//   - Reset (async assert, sync release): state IDLE; bit_out, inv_sel, bit_valid,
//     frame_start, frame_done, bit_index = 0; shift register cleared. After reset
//     load_ready = 1.
//   - FSM: IDLE, SHIFT.
//     IDLE: load_ready=1, bit_valid=0. Accept on load_valid&load_ready (rising edge):
//       capture word and invert flag, go to SHIFT, first bit presented the next cycle
//       (1-cycle latency), bit_index=0, frame_start=1.
//     SHIFT: bit_valid=1. On an edge with advance=1, move to the next bit and increment
//       bit_index. With advance=0, all outputs and state hold.
//       The last bit (bit_index=WIDTH-1) is presented with frame_done=1.
//       load_ready=1 only on the last bit with advance=1.
//       Last bit, advance=1, no accept: go to IDLE; bit_valid=0 next cycle.
//       Last bit, advance=1, load_valid=1: back-to-back. The new word's first bit
//       follows on the next cycle with no bubble, and inv_sel switches to the new flag.
//   - load_ready is combinational from state/bit_index/advance; it never depends on
//     load_valid. load_valid while not ready is ignored; the captured word is unchanged.
//   - inv_sel is registered and changes only at a frame boundary, never mid-frame.
//   - frame_start and frame_done are gated by bit_valid, and both hold during stalls.
//   - Outputs are registered; the mux output z = inv_sel ? ~bit_out : bit_out.
//   - Reset asserted mid-frame aborts the frame at once; no partial-frame flush after
//     release.
// TESTING  (WIDTH=8, LSB_FIRST=0 unless stated)
//   1. Load 8'hA5, invert=0, advance=1 -> bit_out 1,0,1,0,0,1,0,1 on cycles 1..8 after
//      accept; inv_sel=0; frame_start on cycle 1, frame_done on cycle 8; then IDLE.
//   2. Load 8'hA5, invert=1 -> inv_sel=1 for all 8 bits, same bit_out; the mux model
//      gives z = 0,1,0,1,1,0,1,0.
//   3. Back-to-back: load 8'hFF inv=0, hold load_valid with 8'h00 inv=1 -> 16
//      consecutive valid bits, no gap; inv_sel goes 0->1 exactly on bit 9;
//      load_ready high only on bits 8 and 16.
//   4. Stall: advance=0 for 3 cycles at bit_index=3 -> bit_out/bit_index frozen for 3
//      cycles, frame still totals 8 bits; load_valid pulsed mid-frame is ignored.
//   5. Reset at bit_index=4 -> all outputs 0 immediately (async), load_ready=1 after
//      release; next load 8'h3C serializes 0,0,1,1,1,1,0,0 from bit 0.
//   6. LSB_FIRST=1, load 8'h01 -> bit_out 1,0,0,0,0,0,0,0.

Source files
------------

// File: rtl/serial_bit_feeder.sv
// Serializes one parallel word per frame into the conditional-invert mux,
// holding the mux select constant for the whole frame.
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0,
  localparam int IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic          load_invert,
  input  logic          advance,
  output logic          bit_out,
  output logic          inv_sel,
  output logic          bit_valid,
  output logic          frame_start,
  output logic          frame_done,
  output logic [IW-1:0] bit_index
);

  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
  localparam logic [IW-1:0] PREV = IW'(WIDTH - 2);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic             last;
  logic             accept;
  logic             step;

  function automatic logic head(input logic [WIDTH-1:0] d);
    return LSB_FIRST ? d[0] : d[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] tail(input logic [WIDTH-1:0] d);
    return LSB_FIRST ? (d >> 1) : (d << 1);
  endfunction

  assign last       = (state == SHIFT) && (bit_index == LAST);
  assign load_ready = (state == IDLE) || (last && advance);
  assign accept     = load_valid && load_ready;
  assign step       = (state == SHIFT) && advance;

  // shreg holds the bits not yet presented; bit_out is the live one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_out     <= 1'b0;
      inv_sel     <= 1'b0;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      bit_index   <= '0;
    end else begin
      unique case (1'b1)
        accept: begin
          state       <= SHIFT;
          shreg       <= tail(load_data);
          bit_out     <= head(load_data);
          inv_sel     <= load_invert;
          bit_valid   <= 1'b1;
          frame_start <= 1'b1;
          frame_done  <= 1'b0;
          bit_index   <= '0;
        end
        step && last && !load_valid: begin
          state       <= IDLE;
          bit_valid   <= 1'b0;
          frame_start <= 1'b0;
          frame_done  <= 1'b0;
          bit_index   <= '0;
        end
        step && !last: begin
          shreg       <= tail(shreg);
          bit_out     <= head(shreg);
          frame_start <= 1'b0;
          frame_done  <= (bit_index == PREV);
          bit_index   <= bit_index + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
